// File: rtl/seg_demod_decide.sv
// seg_demod_decide: recovers the per-segment if/else condition bit.
// Each accepted segment is compared against both reference words; the
// difference of absolute distances is summed over SAMPLES_PER_BIT samples
// and the sign of the sum decides the bit (ties go to the else-branch).
// Pipeline: stage 1 registers the two distances, stage 2 accumulates,
// and the decision register presents the result two edges after the last
// sample of a bit.
//
// Handshake: seg_valid qualifies segment_combine for exactly one edge and
// is always consumed (no ready, no backpressure); bit_valid is a one-cycle
// strobe qualifying bit_out/bit_metric, which then hold until the next one.
module seg_demod_decide #(
    parameter int SEG_W           = 32,
    parameter int SAMPLES_PER_BIT = 8,
    parameter int ACC_W           = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seg_valid,
    input  logic [SEG_W-1:0] segment_combine,
    input  logic [SEG_W-1:0] ref_if,
    input  logic [SEG_W-1:0] ref_else,
    input  logic             sync_clear,
    output logic             bit_valid,
    output logic             bit_out,
    output logic [ACC_W-1:0] bit_metric,
    output logic             busy,
    output logic             state_dbg
);

    localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t state;

    // sample counter and pipeline registers
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;

    logic             s1_valid;
    logic             s1_first;
    logic             s1_last;
    logic [SEG_W:0]   s1_abs_i;
    logic [SEG_W:0]   s1_abs_e;

    logic             s2_valid;
    logic             s2_last;
    logic [ACC_W-1:0] acc;

    // combinational helpers
    logic signed [SEG_W:0]   diff_i;
    logic signed [SEG_W:0]   diff_e;
    logic        [SEG_W:0]   abs_i;
    logic        [SEG_W:0]   abs_e;
    logic signed [SEG_W+1:0] term;
    logic        [ACC_W-1:0] term_ext;
    logic        [ACC_W-1:0] sum;
    logic                    s2_valid_next;
    logic                    busy_next;

    // a sample colliding with sync_clear is dropped
    assign accept    = seg_valid & ~sync_clear;
    assign state_dbg = (state == ACCUM);

    // stage-1 distances, formed one bit wider so the difference cannot wrap
    always_comb begin
        diff_i = $signed({segment_combine[SEG_W-1], segment_combine})
               - $signed({ref_if[SEG_W-1], ref_if});
        diff_e = $signed({segment_combine[SEG_W-1], segment_combine})
               - $signed({ref_else[SEG_W-1], ref_else});
        abs_i  = diff_i[SEG_W] ? (SEG_W+1)'(-diff_i) : (SEG_W+1)'(diff_i);
        abs_e  = diff_e[SEG_W] ? (SEG_W+1)'(-diff_e) : (SEG_W+1)'(diff_e);
    end

    // stage-2 term (positive favours the if-branch) and running sum
    always_comb begin
        term     = $signed({1'b0, s1_abs_e}) - $signed({1'b0, s1_abs_i});
        term_ext = {{(ACC_W-SEG_W-2){term[SEG_W+1]}}, term};
        sum      = s1_first ? term_ext : (acc + term_ext);
    end

    // next counter value and next occupancy, shared by counter and FSM
    always_comb begin
        cnt_next = cnt;
        if (sync_clear) begin
            cnt_next = '0;
        end else if (seg_valid) begin
            cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        s2_valid_next = s1_valid & ~sync_clear;
        busy_next     = (cnt_next != '0) | accept | s2_valid_next;
    end

    // sample counter and stage-1 capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_abs_i <= '0;
            s1_abs_e <= '0;
        end else begin
            cnt      <= cnt_next;
            s1_valid <= accept;
            if (accept) begin
                s1_first <= (cnt == '0);
                s1_last  <= (cnt == CNT_LAST);
                s1_abs_i <= abs_i;
                s1_abs_e <= abs_e;
            end
        end
    end

    // stage-2 accumulation; the accumulator reloads on the first sample of a bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            acc      <= '0;
        end else if (sync_clear) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            acc      <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                acc     <= sum;
            end
        end
    end

    // decision register: a final sum still in stage 2 is lost to sync_clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_valid  <= 1'b0;
            bit_out    <= 1'b0;
            bit_metric <= '0;
        end else begin
            bit_valid <= s2_valid & s2_last & ~sync_clear;
            if (s2_valid && s2_last && !sync_clear) begin
                bit_metric <= acc;
                bit_out    <= ~acc[ACC_W-1] & (|acc);
            end
        end
    end

    // control FSM: ACCUM while a partial bit or an in-flight sample exists
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE:    state <= busy_next ? ACCUM : IDLE;
                ACCUM:   state <= busy_next ? ACCUM : IDLE;
                default: state <= IDLE;
            endcase
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_seg_demod_decide.sv
// Bench for seg_demod_decide: directed patterns plus randomized traffic,
// checked every cycle against a sample-list reference model.
module tb_seg_demod_decide;

    localparam int SEG_W = 32;
    localparam int SPB   = 8;
    localparam int ACC_W = 40;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic             seg_valid = 1'b0;
    logic             sync_clear = 1'b0;
    logic [SEG_W-1:0] segment_combine = '0;
    logic [SEG_W-1:0] ref_if = '0;
    logic [SEG_W-1:0] ref_else = '0;
    logic             bit_valid;
    logic             bit_out;
    logic [ACC_W-1:0] bit_metric;
    logic             busy;
    logic             state_dbg;

    seg_demod_decide #(.SEG_W(SEG_W), .SAMPLES_PER_BIT(SPB), .ACC_W(ACC_W)) dut (
        .clk(clk),
        .reset(reset),
        .seg_valid(seg_valid),
        .segment_combine(segment_combine),
        .ref_if(ref_if),
        .ref_else(ref_else),
        .sync_clear(sync_clear),
        .bit_valid(bit_valid),
        .bit_out(bit_out),
        .bit_metric(bit_metric),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    // scoreboard state
    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               n_strobes = 0;
    bit               checking = 1'b0;
    longint           cur_q[$];
    logic [ACC_W-1:0] exp_q[$];
    int               due_q[$];
    int               last_acc = -10;
    logic [ACC_W-1:0] held_metric = '0;
    logic             ev;
    logic             exp_busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint sx(input logic [SEG_W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // reference model: per-bit list of terms; a finished bit is due two edges later
    always @(posedge clk) begin
        longint s;
        longint total;
        cyc++;
        if (!reset) begin
            cur_q.delete();
            exp_q.delete();
            due_q.delete();
            held_metric = '0;
            last_acc = -10;
        end else if (sync_clear) begin
            cur_q.delete();
            while (due_q.size() > 0 && due_q[$] >= cyc) begin
                void'(due_q.pop_back());
                void'(exp_q.pop_back());
            end
            last_acc = -10;
        end else if (seg_valid) begin
            s = sx(segment_combine);
            cur_q.push_back(labs(s - sx(ref_else)) - labs(s - sx(ref_if)));
            last_acc = cyc;
            if (cur_q.size() == SPB) begin
                total = 0;
                foreach (cur_q[i]) total += cur_q[i];
                exp_q.push_back(ACC_W'(total));
                due_q.push_back(cyc + 2);
                cur_q.delete();
            end
        end
    end

    // monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            ev = (due_q.size() > 0) && (due_q[0] == cyc);
            chk("bit_valid", 64'(bit_valid), 64'(ev));
            if (bit_valid === 1'b1) n_strobes++;
            if (ev) begin
                held_metric = exp_q.pop_front();
                void'(due_q.pop_front());
            end
            while (due_q.size() > 0 && due_q[0] < cyc) begin
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end
            chk("bit_metric", 64'(bit_metric), 64'(held_metric));
            chk("bit_out", 64'(bit_out), 64'($signed(held_metric) > 0));
            exp_busy = reset && ((cur_q.size() != 0) || (cyc - last_acc <= 1));
            chk("busy", 64'(busy), 64'(exp_busy));
        end
    end

    // driver tasks
    task automatic step(input logic v, input logic [SEG_W-1:0] s, input logic clr);
        @(negedge clk);
        #1;
        seg_valid       = v;
        segment_combine = s;
        sync_clear      = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, $urandom, 1'b0);
    endtask

    task automatic set_refs(input logic [SEG_W-1:0] ri, input logic [SEG_W-1:0] re);
        @(negedge clk);
        #1;
        seg_valid  = 1'b0;
        sync_clear = 1'b0;
        ref_if     = ri;
        ref_else   = re;
    endtask

    task automatic send_bit(input logic [SEG_W-1:0] s, input bit gaps);
        for (int i = 0; i < SPB; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
            step(1'b1, s, 1'b0);
        end
    endtask

    initial begin
        int s0;
        int r;
        logic [ACC_W-1:0] v;
        logic [SEG_W-1:0] base;

        // reset state
        @(posedge clk);
        checking = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        idle(2);

        // if-pattern
        set_refs(32'h0000_0100, 32'hFFFF_FF00);
        s0 = n_strobes;
        send_bit(32'h0000_0100, 1'b0);
        idle(4);
        chk("if_strobes", 64'(n_strobes - s0), 64'd1);
        chk("if_metric", 64'(bit_metric), 64'd4096);
        chk("if_bit", 64'(bit_out), 64'd1);

        // else-pattern and tie
        send_bit(32'hFFFF_FF00, 1'b0);
        idle(4);
        v = ACC_W'(-64'sd4096);
        chk("else_metric", 64'(bit_metric), 64'(v));
        chk("else_bit", 64'(bit_out), 64'd0);
        send_bit(32'h0000_0000, 1'b0);
        idle(4);
        chk("tie_metric", 64'(bit_metric), 64'd0);
        chk("tie_bit", 64'(bit_out), 64'd0);

        // back-to-back with gaps: bits 1,0,1
        s0 = n_strobes;
        send_bit(32'h0000_0100, 1'b1);
        send_bit(32'hFFFF_FF00, 1'b1);
        send_bit(32'h0000_0100, 1'b1);
        idle(4);
        chk("b2b_strobes", 64'(n_strobes - s0), 64'd3);
        chk("b2b_last_bit", 64'(bit_out), 64'd1);

        // clear collision on the 5th sample
        s0 = n_strobes;
        repeat (4) step(1'b1, 32'h0000_0100, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b1);
        idle(1);
        @(negedge clk);
        #1;
        chk("clr_busy", 64'(busy), 64'd0);
        idle(3);
        chk("clr_strobes", 64'(n_strobes - s0), 64'd0);
        send_bit(32'hFFFF_FF00, 1'b0);
        idle(4);
        chk("clr_next_strobes", 64'(n_strobes - s0), 64'd1);
        chk("clr_next_bit", 64'(bit_out), 64'd0);

        // extremes
        set_refs(32'h7FFF_FFFF, 32'h8000_0000);
        send_bit(32'h8000_0000, 1'b0);
        idle(4);
        v = ACC_W'(-64'sd34359738360);
        chk("ext_metric", 64'(bit_metric), 64'(v));
        chk("ext_bit", 64'(bit_out), 64'd0);

        // mid-stream reset, then a fresh bit
        set_refs(32'h0000_0100, 32'hFFFF_FF00);
        repeat (3) step(1'b1, 32'h0000_0100, 1'b0);
        @(negedge clk);
        #1;
        reset     = 1'b0;
        seg_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_bit_metric", 64'(bit_metric), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        s0 = n_strobes;
        send_bit(32'h0000_0100, 1'b1);
        idle(4);
        chk("rst_next_strobes", 64'(n_strobes - s0), 64'd1);
        chk("rst_next_metric", 64'(bit_metric), 64'd4096);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            if (cur_q.size() == 0 && (seg_valid == 1'b0 || sync_clear == 1'b1)
                && $urandom_range(0, 3) == 0) begin
                set_refs($urandom, $urandom);
            end
            r = $urandom_range(0, 99);
            base = ($urandom_range(0, 1) == 1) ? ref_if : ref_else;
            if (r < 3) begin
                step(1'($urandom_range(0, 1)), $urandom, 1'b1);
            end else if (r < 20) begin
                idle(1);
            end else if (r < 30) begin
                step(1'b1, $urandom, 1'b0);
            end else begin
                step(1'b1, base + SEG_W'($urandom_range(0, 64)) - SEG_W'(32), 1'b0);
            end
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_demod_decide.md
# seg_demod_decide

Receive-side counterpart of the per-segment if/else modulator. It takes the stream of combined 32-bit segments, in which each segment carries either the if-branch or the else-branch reference word. Over a fixed number of samples per bit, it accumulates a signed distance metric against both reference words and recovers the original condition bit. It sits after the segment channel and feeds recovered bits to the bit sink. It is fully pipelined, has no backpressure, and processes back-to-back bits.

## Interface
- `SEG_W`, default 32: segment and reference word width. Words are two's-complement signed.
- `SAMPLES_PER_BIT`, default 8: segments accumulated per decided bit. Must be 1 or greater.
- `ACC_W`, default 40: metric accumulator width. Must be at least `SEG_W+2+clog2(SAMPLES_PER_BIT)`.
- `clk`, in, 1: single clock. All logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `seg_valid`, in, 1: `segment_combine` is valid this cycle and is consumed at the edge.
- `segment_combine`, in, `SEG_W`: received combined segment.
- `ref_if`, in, `SEG_W`: if-branch reference word. It must be stable while a bit is in progress.
- `ref_else`, in, `SEG_W`: else-branch reference word. It must be stable while a bit is in progress.
- `sync_clear`, in, 1: synchronous flush of any partial bit.
- `bit_valid`, out, 1: one-cycle strobe. `bit_out` and `bit_metric` are valid.
- `bit_out`, out, 1: recovered condition bit. 1 means the if-branch.
- `bit_metric`, out, `ACC_W`: signed final metric of the decided bit.
- `busy`, out, 1: a partial bit or an in-flight sample exists.

## Operation
- Stage 1 captures each accepted sample at the edge where `seg_valid` is 1:
  - `dI = |seg − ref_if|` and `dE = |seg − ref_else|`.
  - Each difference is formed at `SEG_W+1` bits signed. Its absolute value is taken as `SEG_W+1` bits unsigned, with no saturation.
  - A `last` tag is set when the sample counter equals `SAMPLES_PER_BIT−1`.
- Sample counter:
  - Range 0..`SAMPLES_PER_BIT−1`. Increments on each accepted sample.
  - Wraps to 0 after the last sample of a bit.
- Stage 2 accumulates:
  - `term = dE − dI`, sign-extended to `ACC_W`.
  - On the first sample of a bit, the accumulator loads `term`. Otherwise it adds `term`.
  - On a `last`-tagged sample, the final sum goes directly to the decision register and the accumulator is free for the next bit in the same cycle.
- Decision:
  - `bit_out = 1` if the final metric is greater than 0.
  - `bit_out = 0` if the final metric is 0 or less. Ties resolve to the else-branch.
  - `bit_metric` holds the final sum.
- Control states:
  - IDLE: counter is 0 and the pipeline is empty. Go to ACCUM on `seg_valid`.
  - ACCUM: counter is not 0, or a sample is in the pipe. Go to IDLE when the last sample drains and no new sample has arrived.
- `busy` is 1 in ACCUM and 0 in IDLE.
- Gaps in `seg_valid` pause accumulation without loss.
- `sync_clear` resets the counter, the accumulator and the stage-1/stage-2 valid flags.
  - If `sync_clear` and `seg_valid` are both 1 in the same cycle, the clear wins and the sample is dropped.
  - A bit whose last sample is still in stage 1 or stage 2 is discarded and produces no `bit_valid`.
  - A `bit_valid` already registered still completes.
- Reset values:
  - `bit_valid` = 0, `bit_out` = 0, `bit_metric` = 0, `busy` = 0.
  - Counter = 0, accumulator = 0, pipeline valids = 0.
- Reset mid-bit discards all partial state. Reset deassertion is synchronized externally.

## Timing
- The last sample of a bit, accepted at edge E, produces `bit_valid` high in the cycle following edge E+2. Latency is 2 cycles.
- `bit_valid` is high for exactly one cycle per bit. `bit_out` and `bit_metric` hold their value until the next `bit_valid`.
- Throughput is one sample per cycle sustained. Consecutive bits produce `bit_valid` strobes exactly `SAMPLES_PER_BIT` cycles apart.
- There is no combinational path from any input to any output.

## Test plan
- Reset: assert `reset`=0 mid-stream → all outputs 0 and `busy`=0. After release, the first bit decodes correctly from fresh samples.
- If-pattern decode: `ref_if`=0x00000100, `ref_else`=0xFFFFFF00, eight samples of 0x00000100 on consecutive cycles → one `bit_valid` 2 cycles after the 8th sample, `bit_out`=1, `bit_metric`=4096.
- Else-pattern and tie:
  - Same references, eight samples of 0xFFFFFF00 → `bit_out`=0, `bit_metric`=−4096.
  - Eight samples of 0x00000000 → `bit_out`=0, `bit_metric`=0.
- Back-to-back with gaps: 24 samples alternating if/else patterns per bit, with random single-cycle `seg_valid` gaps → three `bit_valid` strobes with bits 1,0,1. No sample may be lost or double-counted.
- Clear collision: `sync_clear` asserted with `seg_valid` on the 5th sample → no `bit_valid` and `busy`=0 next cycle. The next 8 samples produce exactly one correct bit.
- Extremes:
  - `ref_if`=0x7FFFFFFF, `ref_else`=0x80000000, eight samples of 0x80000000 → per-sample term −(2^32−1), `bit_metric`=−8·(2^32−1), `bit_out`=0.
  - No overflow is allowed at `ACC_W`=40.
